clock_tick_monitor: RTL and testbench
=====================================

# clock_tick_monitor

Consumes the slow divided clock produced by the ripple divider chain (default ÷2^19) and brings it back into the main `clk` domain. It synchronizes `slowClk` and emits a one-cycle `tick` enable per rising edge. It also measures the period in `clk` cycles, declares lock after repeated in-tolerance periods, and flags loss when edges stop. Display-refresh and keypad-scan logic use `tick` instead of clocking directly off the divided clock.

## Interface
- `PERIOD_W`, 24: width of the period counter and `period` output.
- `EXPECTED`, 524288: nominal `slowClk` period in `clk` cycles.
- `TOL`, 16: permitted absolute deviation from `EXPECTED`, inclusive.
- `LOCK_COUNT`, 4: consecutive in-tolerance periods required to lock; must be ≥1.
- `TIMEOUT`, 1048576: `clk` cycles without an edge before `lost` asserts; must be > `EXPECTED`+`TOL` and < 2^`PERIOD_W`.

- `clk`  in  1  system clock. One clock only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `slowClk`  in  1  divided clock, asynchronous to `clk`.
- `tick`  out  1  one-cycle pulse per detected `slowClk` rising edge.
- `period`  out  `PERIOD_W`  last measured period in `clk` cycles; holds between updates.
- `periodValid`  out  1  one-cycle pulse when `period` updates.
- `locked`  out  1  high while in LOCKED.
- `lost`  out  1  high while in LOST.

## Operation
- Synchronizer: two flops (`s1`, `s2`) plus history flop `s3`, all reset to 0. Rising edge is `s2 & ~s3`.
- Cycle counter `cnt` tracks cycles since the last tick or since reset release. It saturates at 2^`PERIOD_W`−1 and never wraps. On an edge it restarts so that `period` equals the number of `clk` cycles between consecutive `tick` pulses.
- Match counter `mcnt` (width ≥ clog2(`LOCK_COUNT`+1)). An in-tolerance period satisfies |measured − `EXPECTED`| ≤ `TOL`.
- States:
  - IDLE (reset state): edge → ACQUIRE. The period is not measured.
  - ACQUIRE: each edge updates `period` and pulses `periodValid`. In-tolerance: `mcnt`+1, and on reaching `LOCK_COUNT` → LOCKED. Out-of-tolerance: `mcnt` = 0.
  - LOCKED: an in-tolerance edge stays in LOCKED. An out-of-tolerance edge → ACQUIRE with `mcnt` = 0, and `locked` drops in the same cycle that `periodValid` reports the bad period.
  - LOST: edge → ACQUIRE with `mcnt` = 0. This edge is not measured because the preceding interval is unknown.
  - From IDLE, ACQUIRE or LOCKED: `cnt` reaching `TIMEOUT` with no edge → LOST, and `mcnt` = 0.
- An edge in the same cycle as the timeout condition: the edge wins and no LOST transition occurs.
- `tick` fires on every detected edge in every state.

## Timing
- Reset values: `tick`=0, `period`=0, `periodValid`=0, `locked`=0, `lost`=0, state=IDLE, `cnt`=0, `mcnt`=0.
- Reset is asynchronous on assertion. Mid-operation reset clears everything immediately, including lock.
- Latency: if `slowClk` is first sampled high at `clk` edge k, then `tick` is high for exactly the cycle after edge k+2.
- `tick`, `periodValid`, `period`, `locked` and `lost` are registered and all update on that same edge. `periodValid` never asserts without `tick`.
- If `slowClk` is already high at reset release, one tick is generated 3 cycles later and treated as a first, unmeasured edge.
- `lost` asserts on the cycle where `TIMEOUT` cycles have elapsed since the last tick (or since reset release).
- Minimum supported `slowClk` high and low times are 2 `clk` cycles each. Shorter pulses may be missed.

## Test plan
Use `EXPECTED`=8, `TOL`=1, `LOCK_COUNT`=3, `TIMEOUT`=20, `PERIOD_W`=8 for all scenarios.
- `slowClk` period 8 (4 high / 4 low) → one-cycle `tick` every 8 cycles. Edge 1 gives no `periodValid`. Edges 2–4 give `periodValid` with `period`=8. `locked`=1 from the edge-4 update.
- Locked, then one period of 11 → `periodValid` with `period`=11 and `locked`=0 in the same cycle. Three more periods of 8 → relock on the third.
- Alternating periods 9 and 7 → always in tolerance, lock after 3 measurements. Periods of 10 → `mcnt` stays 0 and `locked` never asserts.
- Stop `slowClk` while locked → `lost`=1 and `locked`=0 exactly 20 cycles after the last tick. The next edge gives `tick`, `lost`=0, no `periodValid`, and the next measured period is 8.
- Assert `rst_n`=0 mid-period while locked → all outputs 0 asynchronously. Release with `slowClk` high → `tick` 3 cycles later with no `periodValid`.
- An edge arriving exactly when `cnt` reaches 20 → no `lost`, and the period is reported as measured.

Source files
------------

// File: rtl/clock_tick_monitor.sv
// Brings the divided slowClk into the clk domain as a one-cycle tick, measures
// its period in clk cycles, and reports lock (stable period) or loss (no edges).
module clock_tick_monitor #(
  parameter int PERIOD_W   = 24,
  parameter int EXPECTED   = 524288,
  parameter int TOL        = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slowClk,
  output logic                tick,
  output logic [PERIOD_W-1:0] period,
  output logic                periodValid,
  output logic                locked,
  output logic                lost
);

  localparam int MCNT_W = $clog2(LOCK_COUNT + 1);

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] EXP_V     = PERIOD_W'(EXPECTED);
  localparam logic [PERIOD_W-1:0] TOL_V     = PERIOD_W'(TOL);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [MCNT_W-1:0]   LOCK_V    = MCNT_W'(LOCK_COUNT);
  localparam logic [MCNT_W-1:0]   MCNT_ONE  = MCNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                s3_q, s3_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                tick_q, tick_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;

  logic                rise;
  logic [PERIOD_W-1:0] diff;
  logic                in_tol;
  logic                timed_out;
  logic [MCNT_W-1:0]   mcnt_inc;

  always_comb begin
    rise      = s2_q & ~s3_q;
    diff      = (cnt_q >= EXP_V) ? (cnt_q - EXP_V) : (EXP_V - cnt_q);
    in_tol    = (diff <= TOL_V);
    timed_out = (cnt_q >= TIMEOUT_V);
    mcnt_inc  = mcnt_q + MCNT_ONE;

    s1_d     = slowClk;
    s2_d     = s1_q;
    s3_d     = s2_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    mcnt_d   = mcnt_q;
    state_d  = state_q;
    period_d = period_q;
    pv_d     = 1'b0;
    tick_d   = rise;

    // cnt restarts at 1 so that on the next edge it holds the tick-to-tick distance
    if (rise) begin
      cnt_d = CNT_ONE;
      case (state_q)
        IDLE, LOST: begin
          state_d = ACQUIRE;
          mcnt_d  = '0;
        end
        ACQUIRE: begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          if (in_tol) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LOCK_V) begin
              state_d = LOCKED;
            end
          end else begin
            mcnt_d = '0;
          end
        end
        LOCKED: begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          if (!in_tol) begin
            state_d = ACQUIRE;
            mcnt_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          mcnt_d  = '0;
        end
      endcase
    end else if (timed_out && (state_q != LOST)) begin
      state_d = LOST;
      mcnt_d  = '0;
    end

    locked_d = (state_d == LOCKED);
    lost_d   = (state_d == LOST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      mcnt_q   <= '0;
      tick_q   <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      mcnt_q   <= mcnt_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign tick        = tick_q;
  assign period      = period_q;
  assign periodValid = pv_q;
  assign locked      = locked_q;
  assign lost        = lost_q;

endmodule

// File: tb/tb_clock_tick_monitor.sv
// Drives directed and random slowClk waveforms and compares every cycle against
// an event-level model built from the tick/period/lock/loss rules.
module tb_clock_tick_monitor;

  localparam int PW   = 8;
  localparam int EXP  = 8;
  localparam int TOLR = 1;
  localparam int LCNT = 3;
  localparam int TOUT = 20;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  localparam int M_LOST = 3;

  logic          clk;
  logic          rst_n;
  logic          slowClk;
  logic          tick;
  logic [PW-1:0] period;
  logic          periodValid;
  logic          locked;
  logic          lost;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int n;
  bit hist[$];
  int mMode;
  int mMatch;
  int mLast;
  int mPeriod;

  clock_tick_monitor #(
    .PERIOD_W(PW), .EXPECTED(EXP), .TOL(TOLR), .LOCK_COUNT(LCNT), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slowClk(slowClk), .tick(tick), .period(period),
    .periodValid(periodValid), .locked(locked), .lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0d expected=%0d", name, n, obs, exp);
    end
  endtask

  // The cycle counter starts as if release were a tick one cycle earlier.
  task automatic modelReset();
    n       = 0;
    hist.delete();
    mMode   = M_IDLE;
    mMatch  = 0;
    mLast   = 1;
    mPeriod = 0;
  endtask

  function automatic bit sampleAt(input int k);
    return (k < 1) ? 1'b0 : hist[k-1];
  endfunction

  task automatic applyStimulus(input bit v);
    bit expTick;
    bit expPv;
    int meas;
    bit inTol;
    slowClk = v;
    @(posedge clk);
    n++;
    hist.push_back(v);
    #1;
    expTick = sampleAt(n - 2) && !sampleAt(n - 3);
    expPv   = 1'b0;
    if (expTick) begin
      if (mMode == M_IDLE || mMode == M_LOST) begin
        mMode  = M_ACQ;
        mMatch = 0;
      end else begin
        meas    = n - mLast;
        mPeriod = meas;
        expPv   = 1'b1;
        inTol   = ((meas > EXP) ? meas - EXP : EXP - meas) <= TOLR;
        if (mMode == M_ACQ) begin
          if (inTol) begin
            mMatch++;
            if (mMatch == LCNT) mMode = M_LOCK;
          end else begin
            mMatch = 0;
          end
        end else if (!inTol) begin
          mMode  = M_ACQ;
          mMatch = 0;
        end
      end
      mLast = n;
    end else if (mMode != M_LOST && (n - mLast) >= TOUT) begin
      mMode  = M_LOST;
      mMatch = 0;
    end
    checkOutput("tick", 32'(tick), 32'(expTick));
    checkOutput("periodValid", 32'(periodValid), 32'(expPv));
    checkOutput("period", 32'(period), 32'(mPeriod));
    checkOutput("locked", 32'(locked), 32'(mMode == M_LOCK));
    checkOutput("lost", 32'(lost), 32'(mMode == M_LOST));
  endtask

  task automatic runPeriod(input int hi, input int lo);
    repeat (hi) applyStimulus(1'b1);
    repeat (lo) applyStimulus(1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".tick"}, 32'(tick), 32'd0);
    checkOutput({tag, ".periodValid"}, 32'(periodValid), 32'd0);
    checkOutput({tag, ".period"}, 32'(period), 32'd0);
    checkOutput({tag, ".locked"}, 32'(locked), 32'd0);
    checkOutput({tag, ".lost"}, 32'(lost), 32'd0);
  endtask

  initial begin
    int hi;
    int lo;
    int tot;
    rst_n   = 1'b1;
    slowClk = 1'b0;
    modelReset();
    #2 rst_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    modelReset();

    $display("[TB] nominal lock, bad period, relock");
    repeat (3) applyStimulus(1'b0);
    repeat (5) runPeriod(4, 4);
    runPeriod(4, 7);
    repeat (4) runPeriod(4, 4);

    $display("[TB] alternating 9/7 then out-of-tolerance 10");
    repeat (3) begin
      runPeriod(5, 4);
      runPeriod(4, 3);
    end
    repeat (5) runPeriod(5, 5);

    $display("[TB] loss of edges while locked");
    repeat (5) runPeriod(4, 4);
    repeat (26) applyStimulus(1'b0);
    repeat (4) runPeriod(4, 4);

    $display("[TB] edge exactly at timeout");
    runPeriod(4, 16);
    repeat (4) runPeriod(4, 4);

    $display("[TB] mid-period reset while locked");
    repeat (2) applyStimulus(1'b1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midReset");
    slowClk = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    modelReset();
    runPeriod(4, 4);
    repeat (4) runPeriod(4, 4);

    $display("[TB] randomized periods");
    repeat (60) begin
      if ($urandom_range(0, 2) != 0) begin
        tot = $urandom_range(EXP - TOLR, EXP + TOLR);
        hi  = $urandom_range(2, tot - 2);
        lo  = tot - hi;
      end else begin
        hi = $urandom_range(2, 6);
        lo = $urandom_range(2, 6);
      end
      if ($urandom_range(0, 9) == 0) lo = $urandom_range(TOUT - 3, TOUT + 4);
      runPeriod(hi, lo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
